// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte-stream requesters.
//   Requesters are granted round-robin, and a grant lasts for a whole packet.
//   For each byte the arbiter:
//     - accepts the byte from the owner (one-hot req_ready),
//     - presents the byte on uart_tx_data,
//     - strobes uart_tx_load for one cycle,
//     - waits for uart_tx_empty before taking the next byte.
//   If the owner stalls between bytes for GAP_TIMEOUT cycles, the grant is revoked.
//
// Ports
//   clk_100        in   system clock
//   rst            in   asynchronous active-low reset
//   req_valid      in   per-requester byte valid
//   req_data       in   requester i byte on [i*DATA_LEN +: DATA_LEN]
//   req_last       in   byte is the last of its packet (qualified by valid)
//   req_ready      out  one-hot byte accept, asserted only in LOAD
//   uart_tx_data   out  byte handed to the UART, held until the next load
//   uart_tx_load   out  one-cycle start strobe to the UART
//   uart_tx_empty  in   UART transmitter idle
//   grant_id       out  index of the current owner (meaningful while busy)
//   busy           out  a packet grant is active
//   timeout_err    out  one-cycle pulse when a grant is revoked by the gap timer
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LEN    = 8,
  parameter int GAP_TIMEOUT = 1024,
  parameter int ID_W        = 3
) (
  input  logic                         clk_100,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_LEN-1:0]          uart_tx_data,
  output logic                         uart_tx_load,
  input  logic                         uart_tx_empty,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ARB        = 3'd0,
    LOAD       = 3'd1,
    SETTLE     = 3'd2,
    WAIT_EMPTY = 3'd3,
    NEXT       = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [ID_W-1:0]       grant_id_r, grant_id_s;
  logic [ID_W-1:0]       ptr_r, ptr_s;
  logic                  busy_r, busy_s;
  logic                  last_r, last_s;
  logic [DATA_LEN-1:0]   data_r, data_s;
  logic                  load_r, load_s;
  logic [GAP_W-1:0]      gap_cnt_r, gap_cnt_s;
  logic                  timeout_err_r, timeout_err_s;

  logic [ID_W-1:0]       pick_s;
  logic [DATA_LEN-1:0]   sel_data_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;

  // First valid requester after ptr, scanning ptr+1, ptr+2, ... with wrap at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] pick;
    logic            found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == ID_W'(NUM_REQ - 1)) begin
        idx = '0;
      end else begin
        idx = idx + ID_W'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (idx == ID_W'(i)) && valid[i]) begin
          pick  = idx;
          found = 1'b1;
        end else begin
          found = found;
        end
      end
    end
    return pick;
  endfunction

  // Round-robin winner for the ARB state.
  always_comb begin
    pick_s = rr_pick(req_valid, ptr_r);
  end

  // Mux the current owner's valid/data/last out of the flat request buses.
  always_comb begin
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_r == ID_W'(i)) begin
        sel_data_s  = req_data[i*DATA_LEN +: DATA_LEN];
        sel_valid_s = req_valid[i];
        sel_last_s  = req_last[i];
      end else begin
        sel_data_s  = sel_data_s;
      end
    end
  end

  // Next-state and next-register logic of the packet FSM.
  always_comb begin
    state_s       = state_r;
    grant_id_s    = grant_id_r;
    ptr_s         = ptr_r;
    busy_s        = busy_r;
    last_s        = last_r;
    data_s        = data_r;
    load_s        = 1'b0;
    gap_cnt_s     = gap_cnt_r;
    timeout_err_s = 1'b0;
    case (state_r)
      ARB: begin
        if ((|req_valid) && uart_tx_empty) begin
          grant_id_s = pick_s;
          busy_s     = 1'b1;
          state_s    = LOAD;
        end else begin
          state_s    = ARB;
        end
      end
      LOAD: begin
        // req_ready is high this cycle, so the owner's byte is taken now.
        data_s  = sel_data_s;
        last_s  = sel_last_s;
        load_s  = 1'b1;
        state_s = SETTLE;
      end
      SETTLE: begin
        // The UART may still report empty here; it drops within a cycle of load.
        state_s = WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        if (uart_tx_empty) begin
          if (last_r) begin
            ptr_s   = grant_id_r;
            busy_s  = 1'b0;
            state_s = ARB;
          end else begin
            gap_cnt_s = '0;
            state_s   = NEXT;
          end
        end else begin
          state_s = WAIT_EMPTY;
        end
      end
      NEXT: begin
        if (sel_valid_s) begin
          state_s = LOAD;
        end else if (gap_cnt_r == GAP_MAX) begin
          timeout_err_s = 1'b1;
          ptr_s         = grant_id_r;
          busy_s        = 1'b0;
          state_s       = ARB;
        end else begin
          // Counter never passes GAP_MAX, so it cannot wrap.
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ARB;
      end
    endcase
  end

  // State and output registers; ptr resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      state_r       <= ARB;
      grant_id_r    <= '0;
      ptr_r         <= ID_W'(NUM_REQ - 1);
      busy_r        <= 1'b0;
      last_r        <= 1'b0;
      data_r        <= '0;
      load_r        <= 1'b0;
      gap_cnt_r     <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_id_r    <= grant_id_s;
      ptr_r         <= ptr_s;
      busy_r        <= busy_s;
      last_r        <= last_s;
      data_r        <= data_s;
      load_r        <= load_s;
      gap_cnt_r     <= gap_cnt_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign req_ready    = (state_r == LOAD) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r)
                                          : {NUM_REQ{1'b0}};
  assign uart_tx_data = data_r;
  assign uart_tx_load = load_r;
  assign grant_id     = grant_id_r;
  assign busy         = busy_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter.
//   Stimulus and checking:
//     - Requesters are fed from a source queue.
//     - Every byte expected on the UART is pushed to a scoreboard queue when it is queued
//       at its requester, and popped and compared on each uart_tx_load strobe.
//     - A simple UART model drops empty for CHAR cycles after each load.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DLEN    = 8;
  localparam int GAP     = 32;
  localparam int ID_W    = 3;
  localparam int CHAR    = 5;

  logic                       clk_100 = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DLEN-1:0]    req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic [DLEN-1:0]            uart_tx_data;
  logic                       uart_tx_load;
  logic                       uart_tx_empty;
  logic [ID_W-1:0]            grant_id;
  logic                       busy;
  logic                       timeout_err;

  typedef struct packed { logic [1:0] id; logic [7:0] data; logic last; } src_t;
  typedef struct packed { logic [2:0] id; logic [7:0] data; } exp_t;
  typedef struct { int id; int len; logic [7:0] base; logic [2:0] exp_grant; } vec_t;

  src_t src_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_cnt[NUM_REQ];
  int   to_cnt = 0;
  logic busy_seen = 1'b0;
  int   cnt = 0;
  logic hold = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_LEN(DLEN), .GAP_TIMEOUT(GAP), .ID_W(ID_W)) dut (
    .clk_100(clk_100), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_tx_data(uart_tx_data),
    .uart_tx_load(uart_tx_load), .uart_tx_empty(uart_tx_empty), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_100 = ~clk_100;

  // UART model: busy for CHAR cycles after every load strobe.
  always @(posedge clk_100) begin
    if (uart_tx_load) cnt <= CHAR;
    else if (cnt != 0) cnt <= cnt - 1;
  end
  assign uart_tx_empty = (cnt == 0) && !hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] data, input logic last);
    src_t s;
    exp_t e;
    s.id = 2'(id); s.data = data; s.last = last;
    e.id = 3'(id); e.data = data;
    src_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic send_pkt(input int id, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) push_byte(id, base + 8'(b), (b == len - 1));
  endtask

  task automatic update_inputs();
    logic [NUM_REQ-1:0]      v;
    logic [NUM_REQ*DLEN-1:0] d;
    logic [NUM_REQ-1:0]      l;
    v = '0; d = '0; l = '0;
    // Walk backwards so the oldest entry of each requester ends up on the bus.
    for (int j = src_q.size() - 1; j >= 0; j--) begin
      v[src_q[j].id] = 1'b1;
      d[src_q[j].id*DLEN +: DLEN] = src_q[j].data;
      l[src_q[j].id] = src_q[j].last;
    end
    req_valid = v; req_data = d; req_last = l;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk_100);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: still active after %0d cycles (busy=%0d, %0d bytes pending), required idle",
               tag, n, busy, exp_q.size());
    end
  endtask

  task automatic wait_ready(input string tag, input int id, input int target, input int budget);
    int n;
    n = 0;
    while (ready_cnt[id] < target && n < budget) begin
      @(negedge clk_100);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: req_ready[%0d] count %0d, required %0d", tag, id, ready_cnt[id], target);
    end
  endtask

  // Requester driver: drop bytes transferred in the previous cycle, then present the next ones.
  initial begin : driver
    logic [NUM_REQ-1:0] xfer;
    logic               found;
    forever begin
      @(negedge clk_100);
      xfer = rst ? (req_valid & req_ready) : '0;
      @(posedge clk_100);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i]) begin
          found = 1'b0;
          for (int j = 0; j < src_q.size(); j++) begin
            if (!found && src_q[j].id == 2'(i)) begin
              src_q.delete(j);
              found = 1'b1;
            end
          end
        end
      end
      update_inputs();
    end
  end

  // Monitor: scoreboard compare on each load, one-hot ready check, event counters.
  initial begin : monitor
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    forever begin
      @(negedge clk_100);
      if (rst) begin
        if (busy) busy_seen = 1'b1;
        if (timeout_err) to_cnt++;
        if (req_ready != '0) begin
          chk("ready_onehot", 32'(req_ready), 32'(4'b0001 << grant_id));
          for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ready_cnt[i]++;
        end
        if (uart_tx_load) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL load_unexpected: got byte 0x%0h from id %0d, none expected",
                     uart_tx_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            chk("load_byte", {21'd0, grant_id, uart_tx_data}, {21'd0, e.id, e.data});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[4];
    int   r0;
    int   cyc;
    int   n;

    tbl[0] = '{id: 0, len: 3, base: 8'h41, exp_grant: 3'd0};
    tbl[1] = '{id: 2, len: 2, base: 8'h20, exp_grant: 3'd2};
    tbl[2] = '{id: 1, len: 1, base: 8'h30, exp_grant: 3'd1};
    tbl[3] = '{id: 3, len: 4, base: 8'h50, exp_grant: 3'd3};

    rst = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk_100);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_load", 32'(uart_tx_load), 32'd0);
    chk("rst_data", 32'(uart_tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    @(negedge clk_100);

    // Single-requester packets, one after another.
    for (int r = 0; r < 4; r++) begin
      r0 = ready_cnt[tbl[r].id];
      busy_seen = 1'b0;
      send_pkt(tbl[r].id, tbl[r].len, tbl[r].base);
      wait_idle("tbl_idle", 300);
      chk("tbl_grant", 32'(grant_id), 32'(tbl[r].exp_grant));
      chk("tbl_ready_count", 32'(ready_cnt[tbl[r].id] - r0), 32'(tbl[r].len));
      chk("tbl_busy_seen", 32'(busy_seen), 32'd1);
      chk("tbl_busy_end", 32'(busy), 32'd0);
    end

    // All four at once: 0,1,2,3 in order, and again (ptr back at 3).
    for (int i = 0; i < NUM_REQ; i++) send_pkt(i, 1, 8'h10 + 8'(i));
    wait_idle("rr_idle", 300);
    chk("rr_grant_last", 32'(grant_id), 32'd3);
    for (int i = 0; i < NUM_REQ; i++) send_pkt(i, 1, 8'h18 + 8'(i));
    wait_idle("rr2_idle", 300);

    // req1 mid-packet when req2 arrives: req1 keeps the grant for all 4 bytes.
    r0 = ready_cnt[1];
    send_pkt(1, 4, 8'h60);
    wait_ready("hold_mid", 1, r0 + 2, 200);
    send_pkt(2, 2, 8'h70);
    wait_idle("hold_idle", 300);
    chk("hold_grant", 32'(grant_id), 32'd2);

    // req3 stalls after a non-last byte; gap timer revokes, req0 then wins.
    r0 = ready_cnt[3];
    push_byte(3, 8'h5A, 1'b0);
    wait_ready("gap_load", 3, r0 + 1, 200);
    send_pkt(0, 1, 8'h33);
    n = 0;
    do begin @(negedge clk_100); n++; end while (uart_tx_empty && n < 20);
    n = 0;
    do begin @(negedge clk_100); n++; end while (!uart_tx_empty && n < 50);
    cyc = 0;
    do begin @(negedge clk_100); cyc++; end while (!timeout_err && cyc < GAP + 20);
    chk("gap_cycles", 32'(cyc), 32'(GAP + 1));
    chk("gap_busy", 32'(busy), 32'd0);
    @(negedge clk_100);
    chk("gap_pulse_len", 32'(timeout_err), 32'd0);
    chk("gap_regrant_busy", 32'(busy), 32'd1);
    chk("gap_regrant_id", 32'(grant_id), 32'd0);
    wait_idle("gap_idle", 300);
    chk("gap_count", 32'(to_cnt), 32'd1);

    // Reset in WAIT_EMPTY, then hold the UART busy across release.
    r0 = ready_cnt[1];
    send_pkt(1, 3, 8'h80);
    wait_ready("mrst_load", 1, r0 + 1, 200);
    @(negedge clk_100);
    @(negedge clk_100);
    rst = 1'b0;
    hold = 1'b1;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_load", 32'(uart_tx_load), 32'd0);
    chk("mrst_data", 32'(uart_tx_data), 32'd0);
    chk("mrst_grant", 32'(grant_id), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    src_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_100);
    rst = 1'b1;
    send_pkt(2, 1, 8'h9C);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_100);
      chk("blocked_busy", 32'(busy), 32'd0);
    end
    hold = 1'b0;
    @(negedge clk_100);
    chk("unblock_busy", 32'(busy), 32'd1);
    chk("unblock_grant", 32'(grant_id), 32'd2);
    wait_idle("unblock_idle", 300);
    chk("final_to_count", 32'(to_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
